fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Shares one syn_fifo write port among NUM_REQ producers.
- Round-robin arbitration with a bounded burst lock, so one producer can write up to MAX_BURST consecutive words before the port rotates.
- Gates writes on the FIFO full flag, so a write is never issued into a full FIFO.
- Keeps a write counter and a sticky overflow error for status readout.
- Sits between producer blocks and syn_fifo wr_en/wdata; the read side is untouched.

Parameters:
- NUM_REQ, 4: number of producers (2..8).
- WIDTH, 8: data width; must match syn_fifo WIDTH.
- MAX_BURST, 4: maximum consecutive grants to one owner (>=1).
- CNT_WIDTH, 16: width of the write counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-producer write request, level; held until granted.
- req_data  in  NUM_REQ*WIDTH  flattened data; slice i = producer i.
- gnt  out  NUM_REQ  one-hot grant, combinational; word i is accepted at the posedge where req[i]&gnt[i]=1.
- fifo_full  in  1  from syn_fifo full.
- fifo_overflow  in  1  from syn_fifo overflow.
- fifo_wr_en  out  1  to syn_fifo wr_en; equals |gnt.
- fifo_wdata  out  WIDTH  to syn_fifo wdata; req_data slice of the granted producer, 0 when no grant.
- busy  out  1  1 while the state is BURST.
- wr_count  out  CNT_WIDTH  total accepted writes; wraps modulo 2^CNT_WIDTH.
- err_overflow  out  1  sticky; set when fifo_overflow=1 at a posedge.

Behaviour:
- Registered state: state {IDLE, BURST}, owner (clog2 NUM_REQ bits), burst_cnt (clog2(MAX_BURST)+1 bits), rr_ptr, wr_count, err_overflow.
- Reset (async, rst=1): state=IDLE, owner=0, burst_cnt=0, rr_ptr=0, wr_count=0, err_overflow=0. gnt, fifo_wr_en and fifo_wdata are forced to 0 while rst=1. A reset mid-burst aborts the burst; no partial state is retained.
- lock = (state==BURST) & req[owner] & (burst_cnt<MAX_BURST).
- Grant (combinational):
  - fifo_full=1: gnt=0.
  - else lock=1: gnt=onehot(owner).
  - else: gnt = the first requester with req=1, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ (skip the owner if it is exhausted).
  - No req asserted: gnt=0.
- No bubble on rotation: when the lock ends, the next winner is granted in the same cycle.
- Updates at posedge:
  - New winner w (grant without lock): owner<=w, burst_cnt<=1, rr_ptr<=(w+1) mod NUM_REQ, state<=BURST if MAX_BURST>1, else IDLE.
  - Lock grant: burst_cnt<=burst_cnt+1.
  - No grant and lock=0: state<=IDLE.
  - fifo_full=1 with lock=1: hold state, owner and burst_cnt (stall, not rotate).
  - fifo_full=1 and owner req dropped: state<=IDLE.
- Exhaustion rule: a burst-exhausted owner may not win the next arbitration cycle if any other req is high. Because rr_ptr was already advanced to owner+1, the owner is naturally last in the search order.
- Fairness bound: with all requesters asserting, a producer waits at most (NUM_REQ-1)*MAX_BURST accepted writes.
- wr_count increments by 1 per cycle with fifo_wr_en=1.
- err_overflow is set on fifo_overflow; it is cleared only by rst. It is never expected to set, given the full gating.
- Full/empty boundary: the full flag is sampled in the same cycle as the write. A write into the last free slot is allowed; the next cycle sees full=1 and grants nothing.
- Producers must hold req and data stable until granted. Dropping req without a grant is legal and drops no FIFO state.

Decomposition:
- Shared package fifo_pkg:
  - state enum (IDLE, BURST);
  - default WIDTH/FIFO_SIZE constants shared with syn_fifo.
- Sub-module rr_pick: a combinational rotate-priority encoder with inputs (req, rr_ptr, mask) and outputs (onehot, index, any). It is reusable by the read-side scheduler.

Test Plan:
- Single producer, req[0] held, MAX_BURST=4, FIFO empty -> gnt=0001 on 4 consecutive cycles, then continues with fresh bursts (no competitor); 16 writes fill the FIFO; fifo_full=1 -> gnt=0; wr_count=16; err_overflow=0.
- All 4 req held, FIFO drained continuously -> grant order 0×4, 1×4, 2×4, 3×4, 0×4; no idle cycle between owners.
- Producer 1 in burst (burst_cnt=2), fifo_full asserted 3 cycles -> gnt=0 for 3 cycles; after full drops, owner 1 resumes for the remaining 2 words, then rotates to 2.
- req[2] drops mid-burst after 1 word with req[3] high -> gnt moves to producer 3 in the same cycle; state stays BURST with owner=3.
- Assert rst for 1 cycle mid-burst with owner=2 -> gnt=0 immediately; after reset, wr_count=0, rr_ptr=0, and arbitration restarts from producer 0.
- Force fifo_overflow=1 for one cycle -> err_overflow=1 and stays set until rst.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared types and default sizes for syn_fifo and the blocks
//               that drive its ports (write arbiter, read scheduler).
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Arbiter state: IDLE = no owner holds the port, BURST = owner may keep it
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Defaults shared with syn_fifo so both sides agree on geometry
  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_SIZE  = 16;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotate-priority encoder. Returns the first
//               unmasked requester found searching rr_ptr, rr_ptr+1, ...
//               modulo N. Shared by the write arbiter and read scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  input  logic [N-1:0]  mask,    // 1 = candidate excluded from this search
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] index,
  output logic          any
);

  logic [IW:0]   sum;
  logic [IW-1:0] pos;

  // Walk the requesters in rotated order and latch the first eligible one
  always_comb begin
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    sum    = '0;
    pos    = '0;
    for (int k = 0; k < N; k++) begin
      // rr_ptr < N and k < N, so one conditional subtract is a full modulo
      sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      pos = sum[IW-1:0];
      if (!any && req[pos] && !mask[pos]) begin
        any         = 1'b1;
        index       = pos;
        onehot[pos] = 1'b1;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Shares one syn_fifo write port among NUM_REQ producers using
//               round-robin arbitration with a bounded burst lock, full-flag
//               write gating, a write counter and a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = FIFO_WIDTH,
  parameter int MAX_BURST = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  input  logic                     fifo_full,
  input  logic                     fifo_overflow,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_wdata,
  output logic                     busy,
  output logic [CNT_WIDTH-1:0]     wr_count,
  output logic                     err_overflow
);

  localparam int              IW          = $clog2(NUM_REQ);
  localparam int              BCW         = $clog2(MAX_BURST) + 1;
  localparam logic [BCW-1:0]  BURST_LIMIT = BCW'(MAX_BURST);
  localparam logic [IW-1:0]   LAST_IDX    = IW'(NUM_REQ - 1);

  arb_state_e           state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [BCW-1:0]       burst_cnt_q, burst_cnt_d;
  logic [CNT_WIDTH-1:0] wr_count_q, wr_count_d;
  logic                 err_overflow_q, err_overflow_d;

  logic                 lock;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic [IW-1:0]        pick_index;
  logic                 pick_any;

  // rr_ptr already sits one past the last winner, so an exhausted owner is
  // naturally searched last; nothing needs masking here.
  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .mask   ({NUM_REQ{1'b0}}),
    .onehot (pick_onehot),
    .index  (pick_index),
    .any    (pick_any)
  );

  // Owner keeps the port while it still requests and has burst budget left
  assign lock = (state_q == BURST) && req[owner_q] && (burst_cnt_q < BURST_LIMIT);

  // Grant: nothing while full or in reset, owner on lock, else next RR winner
  always_comb begin
    gnt = '0;
    if (!rst && !fifo_full) begin
      if (lock) begin
        gnt[owner_q] = 1'b1;
      end else if (pick_any) begin
        gnt = pick_onehot;
      end
    end
  end

  assign fifo_wr_en = |gnt;

  // Data mux: grant is one-hot, so OR-ing the gated slices selects the winner
  always_comb begin
    fifo_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        fifo_wdata = fifo_wdata | req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state: a full FIFO stalls a live lock in place rather than rotating
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    rr_ptr_d       = rr_ptr_q;
    burst_cnt_d    = burst_cnt_q;
    wr_count_d     = wr_count_q;
    err_overflow_d = err_overflow_q;

    if (!fifo_full) begin
      if (lock) begin
        burst_cnt_d = burst_cnt_q + 1'b1;
      end else if (pick_any) begin
        owner_d     = pick_index;
        burst_cnt_d = BCW'(1);
        rr_ptr_d    = (pick_index == LAST_IDX) ? '0 : pick_index + 1'b1;
        state_d     = (MAX_BURST > 1) ? BURST : IDLE;
      end else begin
        state_d = IDLE;
      end
    end else if (!lock) begin
      state_d = IDLE;
    end

    if (fifo_wr_en) begin
      wr_count_d = wr_count_q + 1'b1;
    end
    if (fifo_overflow) begin
      err_overflow_d = 1'b1;
    end
  end

  // State registers; reset aborts any burst in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= '0;
      rr_ptr_q       <= '0;
      burst_cnt_q    <= '0;
      wr_count_q     <= '0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      rr_ptr_q       <= rr_ptr_d;
      burst_cnt_q    <= burst_cnt_d;
      wr_count_q     <= wr_count_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign busy         = (state_q == BURST);
  assign wr_count     = wr_count_q;
  assign err_overflow = err_overflow_q;

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Self-checking bench for fifo_wr_arbiter. Random producers and
//               a modelled FIFO fill level drive the DUT; a behavioural model
//               of the arbitration rules predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int MB    = 4;
  localparam int CW    = 16;
  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           fifo_full;
  logic           fifo_overflow;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_wdata;
  logic           busy;
  logic [CW-1:0]  wr_count;
  logic           err_overflow;

  // Behavioural model: who holds the port, words used, where search resumes
  logic [W-1:0] pdata [N];
  bit  m_busy;
  int  m_owner;
  int  m_used;
  int  m_next;
  int  m_count;
  bit  m_err;
  int  level;
  int  last_g;

  int vectors     = 0;
  int miscompares = 0;

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .WIDTH     (W),
    .MAX_BURST (MB),
    .CNT_WIDTH (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_data      (req_data),
    .gnt           (gnt),
    .fifo_full     (fifo_full),
    .fifo_overflow (fifo_overflow),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_wdata    (fifo_wdata),
    .busy          (busy),
    .wr_count      (wr_count),
    .err_overflow  (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic pack_data();
    for (int i = 0; i < N; i++) begin
      req_data[i*W +: W] = pdata[i];
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_used  = 0;
    m_next  = 0;
    m_count = 0;
    m_err   = 1'b0;
  endtask

  // One cycle: inputs already driven at this negedge; check, then advance
  task automatic step(input int drain_pct, input int want_owner);
    int  g;
    int  cand;
    bit  keep;
    bit  drain;
    logic [31:0] exp_g;
    if (rst) model_reset();
    fifo_full = (level >= DEPTH);
    #1;
    keep = m_busy && req[m_owner] && (m_used < MB);
    g = -1;
    if (!rst && !fifo_full) begin
      if (keep) begin
        g = m_owner;
      end else begin
        for (int k = 0; k < N; k++) begin
          cand = (m_next + k) % N;
          if (g < 0 && req[cand]) g = cand;
        end
      end
    end
    exp_g = (g < 0) ? 32'd0 : (32'd1 << g);
    chk("gnt",          32'(gnt),          exp_g);
    chk("wr_en",        32'(fifo_wr_en),   32'(g >= 0));
    chk("wdata",        32'(fifo_wdata),   (g < 0) ? 32'd0 : 32'(pdata[g]));
    chk("busy",         32'(busy),         32'(m_busy));
    chk("wr_count",     32'(wr_count),     32'(m_count % 65536));
    chk("err_overflow", 32'(err_overflow), 32'(m_err));
    if (want_owner >= 0) chk("rr_order", 32'(gnt), 32'd1 << want_owner);

    if (!rst) begin
      if (g >= 0) begin
        m_count++;
        if (keep) begin
          m_used++;
        end else begin
          m_owner = g;
          m_used  = 1;
          m_next  = (g + 1) % N;
          m_busy  = (MB > 1);
        end
      end else if (!keep) begin
        m_busy = 1'b0;
      end
      if (fifo_overflow) m_err = 1'b1;
    end
    drain  = (level > 0) && (($urandom % 100) < drain_pct);
    level  = level - int'(drain) + int'(g >= 0);
    last_g = g;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Producers hold req/data until accepted; occasionally withdraw unserved
  task automatic update_producers();
    for (int i = 0; i < N; i++) begin
      if (req[i] && last_g == i) begin
        req[i]   = (($urandom % 100) < 70);
        pdata[i] = W'($urandom);
      end else if (req[i]) begin
        if (($urandom % 100) < 3) req[i] = 1'b0;
      end else if (($urandom % 100) < 30) begin
        req[i]   = 1'b1;
        pdata[i] = W'($urandom);
      end
    end
    pack_data();
  endtask

  initial begin
    int pct;
    rst           = 1'b1;
    req           = '0;
    fifo_overflow = 1'b0;
    fifo_full     = 1'b0;
    level         = 0;
    last_g        = -1;
    for (int i = 0; i < N; i++) pdata[i] = '0;
    pack_data();
    model_reset();
    @(negedge clk);
    step(100, -1);
    rst = 1'b0;

    // All producers requesting, FIFO drained every cycle: strict 4-word turns
    req = '1;
    for (int i = 0; i < N; i++) pdata[i] = W'($urandom);
    pack_data();
    for (int k = 0; k < 20; k++) begin
      step(100, (k / MB) % N);
      if (last_g >= 0) pdata[last_g] = W'($urandom);
      pack_data();
    end

    // Randomised traffic with fill/drain phases, overflow pulses and resets
    for (int c = 0; c < 3000; c++) begin
      case ((c / 500) % 3)
        0:       pct = 90;
        1:       pct = 25;
        default: pct = 60;
      endcase
      rst           = (($urandom % 300) == 0);
      fifo_overflow = (($urandom % 250) == 0);
      step(pct, -1);
      update_producers();
    end
    rst           = 1'b0;
    fifo_overflow = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire
